// File: rtl/rst_pkg.sv
// Shared types, constants and helpers for the reset sequencer.
//   state_e   : sequencer FSM states
//   clog2     : ceiling log2 (returns at least 1)
//   max_u     : unsigned maximum
//   DEF_*     : default parameter values
package rst_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_NR_SAMPLES   = 10;
  localparam int unsigned DEF_PLL_PULSE    = 4;
  localparam int unsigned DEF_LOCK_STABLE  = 100;
  localparam int unsigned DEF_LOCK_TIMEOUT = 4096;
  localparam int unsigned DEF_NR_DOMAINS   = 4;
  localparam int unsigned DEF_STAGGER      = 16;

  // Bits needed to hold values 0..v-1; never less than 1 so vectors stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchronises an asynchronous active-high button and emits a one-cycle
// press pulse when NR_SAMPLES consecutive synchronised high samples are seen.
//   clk, rst_n : clock, synchronous active-low reset
//   din_i      : raw asynchronous input
//   press_o    : registered single-cycle pulse on a new qualified press
module sync_debounce #(
  parameter int unsigned NR_SAMPLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic press_o
);

  logic [1:0]            sync_q;
  logic [NR_SAMPLES-1:0] shift_q;
  logic [NR_SAMPLES-1:0] shift_d;
  logic                  press_q;

  always_comb begin
    shift_d = {shift_q[NR_SAMPLES-2:0], sync_q[1]};
  end

  // Pulse only on the transition into all-ones so a held button fires once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      shift_q <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], din_i};
      shift_q <= shift_d;
      press_q <= (&shift_d) & ~(&shift_q);
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/rst_sequencer.sv
// Board reset sequencer: debounces the push-button reset, pulses the PLL
// reset, waits for a stable lock (retrying the PLL on timeout), then releases
// NR_DOMAINS domain resets in staggered order and watches for lock loss.
//   clk, rst_n  : clock, synchronous active-low reset
//   noisy_rst   : raw push-button, active-high, asynchronous
//   pll_locked  : PLL lock, asynchronous
//   pll_rst     : PLL reset, active-high
//   dom_rst     : domain resets, active-high, bit 0 released first
//   seq_done    : high while in RUN
//   lock_lost   : sticky flag, set on lock loss in RUN
module rst_sequencer
  import rst_pkg::*;
#(
  parameter int unsigned NR_SAMPLES   = DEF_NR_SAMPLES,
  parameter int unsigned PLL_PULSE    = DEF_PLL_PULSE,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned NR_DOMAINS   = DEF_NR_DOMAINS,
  parameter int unsigned STAGGER      = DEF_STAGGER
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  noisy_rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NR_DOMAINS-1:0] dom_rst,
  output logic                  seq_done,
  output logic                  lock_lost
);

  localparam int unsigned CW = clog2(max_u(LOCK_TIMEOUT, NR_DOMAINS * STAGGER) + 1);
  localparam int unsigned SW = clog2(LOCK_STABLE + 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stab_q, stab_d;
  logic [1:0]            lock_sync_q;
  logic                  lock_s;
  logic                  press;
  logic                  pll_rst_q, pll_rst_d;
  logic [NR_DOMAINS-1:0] dom_rst_q, dom_rst_d;
  logic                  seq_done_q, seq_done_d;
  logic                  lock_lost_q, lock_lost_d;
  logic [NR_DOMAINS-1:0] rel_hit_c;

  sync_debounce #(
    .NR_SAMPLES (NR_SAMPLES)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (noisy_rst),
    .press_o (press)
  );

  assign lock_s = lock_sync_q[1];

  // Release point of each domain within the RELEASE phase.
  for (genvar g = 0; g < NR_DOMAINS; g++) begin : g_rel
    assign rel_hit_c[g] = (cnt_q == CW'(g * STAGGER));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    stab_d      = '0;
    pll_rst_d   = 1'b0;
    dom_rst_d   = dom_rst_q;
    seq_done_d  = 1'b0;
    lock_lost_d = lock_lost_q;

    unique case (state_q)
      PLL_RST: begin
        pll_rst_d = 1'b1;
        dom_rst_d = '1;
        if (cnt_q == CW'(PLL_PULSE - 1)) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end

      WAIT_LOCK: begin
        dom_rst_d = '1;
        stab_d    = lock_s ? (stab_q + SW'(1)) : '0;
        if (lock_s && (stab_q == SW'(LOCK_STABLE - 1))) begin
          state_d = RELEASE;
          cnt_d   = '0;
          stab_d  = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = PLL_RST;
          cnt_d     = '0;
          pll_rst_d = 1'b1;
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          dom_rst_d = '1;
        end else if (!dom_rst_q[NR_DOMAINS-1]) begin
          state_d    = RUN;
          cnt_d      = '0;
          seq_done_d = 1'b1;
          dom_rst_d  = '0;
        end else begin
          // Bits only ever clear here, so released domains cannot glitch.
          dom_rst_d = dom_rst_q & ~rel_hit_c;
        end
      end

      RUN: begin
        cnt_d      = cnt_q;
        seq_done_d = 1'b1;
        dom_rst_d  = '0;
        if (!lock_s) begin
          state_d     = WAIT_LOCK;
          cnt_d       = '0;
          seq_done_d  = 1'b0;
          dom_rst_d   = '1;
          lock_lost_d = 1'b1;
        end
      end

      default: begin
        state_d   = PLL_RST;
        cnt_d     = '0;
        pll_rst_d = 1'b1;
        dom_rst_d = '1;
      end
    endcase

    // A qualified press overrides everything but rst_n.
    if (press) begin
      state_d     = PLL_RST;
      cnt_d       = '0;
      stab_d      = '0;
      pll_rst_d   = 1'b1;
      dom_rst_d   = '1;
      seq_done_d  = 1'b0;
      lock_lost_d = 1'b0;
    end
  end

  // State, counters, lock synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      stab_q      <= '0;
      lock_sync_q <= '0;
      pll_rst_q   <= 1'b1;
      dom_rst_q   <= '1;
      seq_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stab_q      <= stab_d;
      lock_sync_q <= {lock_sync_q[0], pll_locked};
      pll_rst_q   <= pll_rst_d;
      dom_rst_q   <= dom_rst_d;
      seq_done_q  <= seq_done_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dom_rst   = dom_rst_q;
  assign seq_done  = seq_done_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed self-checking bench for rst_sequencer with default parameters.
module tb_rst_sequencer;

  logic       clk;
  logic       rst_n;
  logic       noisy_rst;
  logic       pll_locked;
  logic       pll_rst;
  logic [3:0] dom_rst;
  logic       seq_done;
  logic       lock_lost;

  int n_assert;
  int n_fail;

  rst_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .noisy_rst  (noisy_rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .dom_rst    (dom_rst),
    .seq_done   (seq_done),
    .lock_lost  (lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    noisy_rst  = 1'b0;
    pll_locked = 1'b1;

    // Power-up: three reset edges, lock present from the start.
    tick(3);
    chk("rst_pll_rst",   16'(pll_rst),   16'h1);
    chk("rst_dom_rst",   16'(dom_rst),   16'hF);
    chk("rst_seq_done",  16'(seq_done),  16'h0);
    chk("rst_lock_lost", 16'(lock_lost), 16'h0);
    rst_n = 1'b1;

    tick(3);
    chk("pu_pll_hold",   16'(pll_rst), 16'h1);
    tick(1);
    chk("pu_pll_fall",   16'(pll_rst), 16'h0);
    chk("pu_dom_wait",   16'(dom_rst), 16'hF);
    tick(100);
    chk("pu_dom_pre0",   16'(dom_rst), 16'hF);
    tick(1);
    chk("pu_dom0",       16'(dom_rst), 16'hE);
    tick(15);
    chk("pu_dom0_hold",  16'(dom_rst), 16'hE);
    tick(1);
    chk("pu_dom1",       16'(dom_rst), 16'hC);
    tick(16);
    chk("pu_dom2",       16'(dom_rst), 16'h8);
    tick(16);
    chk("pu_dom3",       16'(dom_rst), 16'h0);
    chk("pu_done_pre",   16'(seq_done), 16'h0);
    tick(1);
    chk("pu_done",       16'(seq_done), 16'h1);
    chk("pu_lock_lost",  16'(lock_lost), 16'h0);

    // Lock loss in RUN for 5 cycles.
    pll_locked = 1'b0;
    tick(2);
    chk("ll_dom_still",  16'(dom_rst),  16'h0);
    chk("ll_done_still", 16'(seq_done), 16'h1);
    tick(1);
    chk("ll_dom",        16'(dom_rst),   16'hF);
    chk("ll_flag",       16'(lock_lost), 16'h1);
    chk("ll_pll",        16'(pll_rst),   16'h0);
    chk("ll_done",       16'(seq_done),  16'h0);
    tick(2);
    pll_locked = 1'b1;
    tick(102);
    chk("ll_dom_pre0",   16'(dom_rst), 16'hF);
    chk("ll_pll_low",    16'(pll_rst), 16'h0);
    tick(1);
    chk("ll_dom0",       16'(dom_rst), 16'hE);
    tick(49);
    chk("ll_run",        16'(seq_done),  16'h1);
    chk("ll_sticky",     16'(lock_lost), 16'h1);

    // Bounce: 9-cycle bursts must not count as a press.
    for (int b = 0; b < 3; b++) begin
      noisy_rst = 1'b1;
      tick(9);
      noisy_rst = 1'b0;
      tick(9);
    end
    tick(5);
    chk("bn_run",        16'(seq_done),  16'h1);
    chk("bn_pll",        16'(pll_rst),   16'h0);
    chk("bn_flag",       16'(lock_lost), 16'h1);

    // Real press, held well beyond the debounce window.
    noisy_rst = 1'b1;
    tick(12);
    chk("pr_pre_pll",    16'(pll_rst),   16'h0);
    chk("pr_pre_flag",   16'(lock_lost), 16'h1);
    tick(1);
    chk("pr_pll",        16'(pll_rst),   16'h1);
    chk("pr_dom",        16'(dom_rst),   16'hF);
    chk("pr_flag_clr",   16'(lock_lost), 16'h0);
    chk("pr_done",       16'(seq_done),  16'h0);
    tick(3);
    chk("pr_pll_hold",   16'(pll_rst), 16'h1);
    tick(1);
    chk("pr_pll_fall",   16'(pll_rst), 16'h0);
    tick(10);
    chk("pr_no_retrig",  16'(pll_rst), 16'h0);
    noisy_rst = 1'b0;

    // Glitchy lock: one low sample right before the stable count completes.
    tick(87);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(3);
    chk("gl_no_release", 16'(dom_rst), 16'hF);
    tick(99);
    chk("gl_pre0",       16'(dom_rst), 16'hF);
    tick(1);
    chk("gl_dom0",       16'(dom_rst), 16'hE);
    tick(16);
    chk("gl_dom1",       16'(dom_rst), 16'hC);

    // Mid-release reset.
    rst_n = 1'b0;
    tick(1);
    chk("mr_dom",        16'(dom_rst),  16'hF);
    chk("mr_pll",        16'(pll_rst),  16'h1);
    chk("mr_done",       16'(seq_done), 16'h0);
    rst_n      = 1'b1;
    pll_locked = 1'b0;

    // Lock timeout: PLL reset re-pulses every 4 + 4096 cycles.
    tick(4);
    chk("to_pll_fall",   16'(pll_rst), 16'h0);
    tick(4095);
    chk("to_pre1",       16'(pll_rst), 16'h0);
    chk("to_dom",        16'(dom_rst), 16'hF);
    tick(1);
    chk("to_retry1",     16'(pll_rst), 16'h1);
    tick(3);
    chk("to_hold1",      16'(pll_rst), 16'h1);
    tick(1);
    chk("to_fall1",      16'(pll_rst), 16'h0);
    tick(4095);
    chk("to_pre2",       16'(pll_rst), 16'h0);
    tick(1);
    chk("to_retry2",     16'(pll_rst), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
